// File: rtl/svc_rv_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : svc_rv_mem_arb_pkg
// Description : Shared types and constants for the svc_rv single-port
//               memory arbiter (FSM states, grant sources, NOP encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package svc_rv_mem_arb_pkg;

    // addi x0, x0, 0 : presented on the fetch channel whenever it is idle
    localparam logic [31:0] c_nop_insn = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE   = 2'd0,
        GNT_IMEM   = 2'd1,
        GNT_DREAD  = 2'd2,
        GNT_DWRITE = 2'd3
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/svc_rv_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : svc_rv_mem_arb_if
// Description : Bundle of core-side (imem/dmem) and memory-side signals
//               around the arbiter. The slave modport is the arbiter's view,
//               the master modport is the surrounding core + memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface svc_rv_mem_arb_if #(
    parameter int XLEN = 32
);
    // core fetch channel
    logic            imem_arvalid;
    logic [XLEN-1:0] imem_araddr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_rvalid;
    // core data channel
    logic            dmem_ren;
    logic [XLEN-1:0] dmem_raddr;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_waddr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_stall;
    // unified memory port
    logic            mem_ren;
    logic [XLEN-1:0] mem_raddr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_we;
    logic [XLEN-1:0] mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;

    modport slave (
        input  imem_arvalid, imem_araddr,
        output imem_rdata, imem_rvalid,
        input  dmem_ren, dmem_raddr,
        output dmem_rdata,
        input  dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb,
        output dmem_stall,
        output mem_ren, mem_raddr,
        input  mem_rdata,
        output mem_we, mem_waddr, mem_wdata, mem_wstrb
    );

    modport master (
        output imem_arvalid, imem_araddr,
        input  imem_rdata, imem_rvalid,
        output dmem_ren, dmem_raddr,
        input  dmem_rdata,
        output dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb,
        input  dmem_stall,
        input  mem_ren, mem_raddr,
        output mem_rdata,
        input  mem_we, mem_waddr, mem_wdata, mem_wstrb
    );

endinterface
`default_nettype wire

// File: rtl/svc_rv_mem_arb_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : svc_sat_counter
// Description : Up-counter that sticks at all-ones, with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module svc_sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    input  wire logic             i_clr,
    output logic [WIDTH-1:0]      o_count
);

    logic [WIDTH-1:0] r_count;

    // count increments until every bit is set, then holds
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/svc_rv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : svc_rv_mem_arb
// Description : Shares one 1-cycle-latency memory port between the core's
//               fetch channel and its load/store channel. A same-cycle
//               fetch/data collision serves the data op first, replays the
//               fetch in a single stall cycle and holds any load result so
//               both responses reach the core together.
// Revision    : 1.0 - initial release
// ============================================================================
module svc_rv_mem_arb
    import svc_rv_mem_arb_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              CNT_W    = 16,
    parameter logic [XLEN-1:0] NOP_INSN = c_nop_insn
) (
    input  wire logic         clock,
    input  wire logic         reset,
    svc_rv_mem_arb_if.slave   bus,
    output logic [CNT_W-1:0]  conflict_count
);

    state_t          r_state;
    state_t          w_state_nxt;
    grant_t          w_grant;
    logic            w_conflict;
    logic            w_replay;
    logic            w_imem_rvalid;

    logic [XLEN-1:0] r_pend_addr;
    logic            r_rsp_imem;
    // Set for the cycle after a granted load. In REPLAY this doubles as the
    // "load result must be held" flag, since the only RUN->REPLAY load is
    // the one that collided with the fetch.
    logic            r_rsp_dmem;
    logic            r_hold_valid;
    logic [XLEN-1:0] r_hold_data;

    assign w_replay = (r_state == ST_REPLAY);

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // grant selection and next state; requests are ignored while replaying
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = GNT_NONE;
        w_conflict  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.dmem_we) begin
                    w_grant = GNT_DWRITE;
                end else if (bus.dmem_ren) begin
                    w_grant = GNT_DREAD;
                end else if (bus.imem_arvalid) begin
                    w_grant = GNT_IMEM;
                end
                w_conflict = bus.imem_arvalid && (bus.dmem_ren || bus.dmem_we);
                if (w_conflict) begin
                    w_state_nxt = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // response tracking, pending fetch address and load hold register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_addr  <= '0;
            r_rsp_imem   <= 1'b0;
            r_rsp_dmem   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (r_state == ST_RUN) begin
            r_rsp_imem   <= (w_grant == GNT_IMEM);
            r_rsp_dmem   <= (w_grant == GNT_DREAD);
            r_hold_valid <= 1'b0;
            if (w_conflict) begin
                r_pend_addr <= bus.imem_araddr;
            end
        end else begin
            r_rsp_imem   <= 1'b1;
            r_rsp_dmem   <= 1'b0;
            r_hold_valid <= r_rsp_dmem;
            if (r_rsp_dmem) begin
                r_hold_data <= bus.mem_rdata;
            end
        end
    end

    // memory port: addresses and data pass straight through; nothing is
    // issued while reset is asserted
    always_comb begin
        bus.mem_ren   = !reset && (w_replay || (w_grant == GNT_DREAD) || (w_grant == GNT_IMEM));
        bus.mem_raddr = w_replay                ? r_pend_addr    :
                        (w_grant == GNT_DREAD)  ? bus.dmem_raddr : bus.imem_araddr;
        bus.mem_we    = !reset && (w_grant == GNT_DWRITE);
        bus.mem_waddr = bus.dmem_waddr;
        bus.mem_wdata = bus.dmem_wdata;
        bus.mem_wstrb = bus.dmem_wstrb;
    end

    // core-facing responses
    always_comb begin
        w_imem_rvalid  = !reset && r_rsp_imem;
        bus.imem_rvalid = w_imem_rvalid;
        bus.imem_rdata  = w_imem_rvalid ? bus.mem_rdata : NOP_INSN;
        bus.dmem_rdata  = r_hold_valid ? r_hold_data : bus.mem_rdata;
        bus.dmem_stall  = !reset && w_replay;
    end

    svc_sat_counter #(
        .WIDTH (CNT_W)
    ) u_conflict_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_inc   (w_conflict),
        .i_clr   (1'b0),
        .o_count (conflict_count)
    );

endmodule
`default_nettype wire

// File: doc/svc_rv_mem_arb.md
Name: svc_rv_mem_arb

Overview:
- Single-port memory arbiter for svc_rv BRAM configs (MEM_TYPE=1).
- Shares one 1-cycle-latency memory port between the core's imem read channel and dmem read/write channel.
- On a same-cycle conflict it serves dmem first, replays the imem read, and stalls the core for exactly one cycle via dmem_stall. To the core, this is indistinguishable from the BRAM+stall model used in formal.
- Sits between svc_rv and a unified svc_rv_soc memory.

Parameters:
- XLEN, 32, data/address width.
- CNT_W, 16, width of saturating conflict counter.
- NOP_INSN, 32'h00000013, imem_rdata value whenever imem_rvalid=0.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- imem_arvalid  in  1  fetch request
- imem_araddr  in  XLEN  fetch byte address
- imem_rdata  out  XLEN  fetch data
- imem_rvalid  out  1  fetch data valid
- dmem_ren  in  1  load request
- dmem_raddr  in  XLEN  load address
- dmem_rdata  out  XLEN  load data
- dmem_we  in  1  store request
- dmem_waddr  in  XLEN  store address
- dmem_wdata  in  XLEN  store data
- dmem_wstrb  in  4  store byte strobes
- dmem_stall  out  1  core freeze
- mem_ren  out  1  memory read strobe
- mem_raddr  out  XLEN  memory read address
- mem_rdata  in  XLEN  memory read data, valid 1 cycle after mem_ren
- mem_we  out  1  memory write strobe
- mem_waddr  out  XLEN  memory write address
- mem_wdata  out  XLEN  memory write data
- mem_wstrb  out  4  memory write strobes
- conflict_count  out  CNT_W  number of replays, saturating

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- States: RUN, REPLAY.
- Registers: state, pend_addr, rsp_imem, rsp_dmem, hold_valid, hold_data, conflict_count.
- Reset values: state=RUN; all response flags 0; conflict_count=0.
- Outputs during reset and the first cycle after it: imem_rvalid=0, imem_rdata=NOP_INSN, dmem_stall=0, mem_ren=0, mem_we=0.
- RUN, grant priority is dmem_we > dmem_ren > imem_arvalid. Exactly one op goes to mem_* per cycle.
  - Address and data pass through combinationally.
  - A granted read sets rsp_imem or rsp_dmem for the next cycle.
- RUN, conflict (imem_arvalid && (dmem_ren||dmem_we)):
  - Issue the dmem op.
  - pend_addr <= imem_araddr.
  - If the op is a read, set hold_pending.
  - Increment conflict_count; it saturates at all-ones.
  - Go to REPLAY.
- REPLAY (exactly 1 cycle):
  - dmem_stall=1.
  - mem_ren=1 with mem_raddr=pend_addr. All core requests are ignored (the core holds them frozen).
  - If hold_pending: hold_data <= mem_rdata, hold_valid <= 1.
  - Set rsp_imem for the next cycle. Return to RUN.
- Response path:
  - imem_rvalid = rsp_imem. imem_rdata = rsp_imem ? mem_rdata : NOP_INSN.
  - dmem_rdata = hold_valid ? hold_data : mem_rdata. hold_valid clears after the first RUN cycle.
- Latency:
  - No conflict: 1 cycle for both channels.
  - Conflict: imem and load data are presented together, 2 cycles after the request, with one stall cycle in between.
- dmem_stall is 0 in RUN. It is never asserted for 2 consecutive cycles, because REPLAY cannot re-enter directly.
- dmem_we && dmem_ren in the same cycle is a protocol violation:
  - The write wins and the read is dropped.
  - The bench must assert this never occurs.
- Reset during REPLAY: returns to RUN next cycle, drops the pending replay and hold, and issues no mem op in the reset cycle.
- Store with no concurrent imem request: no stall, no counter change.

Decomposition:
- Package svc_rv_mem_arb_pkg holds:
  - state enum (RUN, REPLAY)
  - grant-source enum (NONE, IMEM, DREAD, DWRITE)
  - default NOP_INSN constant
- The saturating counter is a natural sub-module: svc_sat_counter (WIDTH, inc, clr→0).
- Everything else is flat.

Test Plan:
- Fetch only: imem_arvalid=1, araddr=0x40, memory word 0x00500093.
  -> mem_ren=1 with raddr=0x40 in the same cycle; next cycle imem_rvalid=1, imem_rdata=0x00500093; dmem_stall stays 0.
- Load/fetch conflict: dmem_ren at 0x100 (data 0xDEADBEEF) plus fetch at 0x44 (0x00000013) in cycle T.
  -> T: mem_raddr=0x100. T+1: dmem_stall=1, mem_raddr=0x44. T+2: dmem_rdata=0xDEADBEEF, imem_rvalid=1, imem_rdata=0x13, stall=0; conflict_count=1.
- Store/fetch conflict: dmem_we at 0x200, wdata=0x12345678, wstrb=4'b0011, plus fetch at 0x48.
  -> T: mem_we with matching fields. T+1: stall=1, fetch replayed. T+2: imem_rvalid=1; no hold used.
- Back-to-back conflicts in 4 consecutive RUN cycles:
  -> dmem_stall alternates 0/1, never high for 2 consecutive cycles; conflict_count=4.
  -> Separately force CNT_W=2 with 5 conflicts -> count saturates at 3.
- Reset asserted in the REPLAY cycle:
  -> Next cycle state=RUN, imem_rvalid=0, imem_rdata=0x13, mem_ren=0, count=0.
- Load with no concurrent fetch at 0x104:
  -> 1-cycle data, no stall, hold_valid stays 0.
